// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the slave-FIFO datapath buffers.
package fifo_pkg;

    localparam int DEFAULT_WIDTH      = 16;
    localparam int DEFAULT_DEPTH_LOG2 = 9;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
module fifo_ram_sdp #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    logic [WIDTH-1:0] mem [0:(1 << DEPTH_LOG2)-1];

    // Write port: storage array is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read port; output register clears on reset and otherwise holds between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill level, watermark flags, read-valid strobe and sticky error flags.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int AFULL_THR  = (1 << DEPTH_LOG2) - 4,
    parameter int AEMPTY_THR = 4
) (
    input  logic                  fifo_clk,
    input  logic                  reset,
    input  logic                  fifo_flush,
    input  logic [WIDTH-1:0]      din,
    input  logic                  write_busy,
    input  logic                  read_busy,
    output logic [WIDTH-1:0]      dout,
    output logic                  dout_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int LEVEL_W = clog2(DEPTH + 1);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LEVEL_W-1:0]    level;
    logic                  push_ok;
    logic                  pop_ok;

    // Flags come only from the registered level, so requests never reach an output combinationally.
    always_comb begin
        fill_level   = level;
        fifo_full    = (level == LEVEL_W'(DEPTH));
        fifo_empty   = (level == '0);
        almost_full  = (level >= LEVEL_W'(AFULL_THR));
        almost_empty = (level <= LEVEL_W'(AEMPTY_THR));
    end

    // Accept decisions; reset and flush cycles swallow all requests.
    always_comb begin
        push_ok = write_busy & ~fifo_full  & ~fifo_flush & ~reset;
        pop_ok  = read_busy  & ~fifo_empty & ~fifo_flush & ~reset;
    end

    // Pointers, level counter, read strobe and sticky error flags.
    always_ff @(posedge fifo_clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (fifo_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            dout_valid <= pop_ok;
            if (write_busy && fifo_full) begin
                overflow <= 1'b1;
            end
            if (read_busy && fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

    fifo_ram_sdp #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk   (fifo_clk),
        .reset (reset),
        .we    (push_ok),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (pop_ok),
        .raddr (rd_ptr),
        .rdata (dout)
    );

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: queue-based reference model compared every cycle, plus literal spot checks.
module tb_sync_fifo_flags;

    logic        fifo_clk;
    logic        reset;
    logic        fifo_flush;
    logic [15:0] din;
    logic        write_busy;
    logic        read_busy;

    logic [15:0] a_dout;
    logic        a_dout_valid, a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf;
    logic [4:0]  a_level;

    logic [7:0]  din_b;
    logic [7:0]  b_dout;
    logic        b_dout_valid, b_full, b_empty, b_afull, b_aempty, b_ovf, b_udf;
    logic [9:0]  b_level;

    int vectors    = 0;
    int miscompares = 0;
    bit check_en   = 0;

    assign din_b = din[7:0];

    sync_fifo_flags #(
        .WIDTH(16), .DEPTH_LOG2(4), .AFULL_THR(12), .AEMPTY_THR(2)
    ) dut_a (
        .fifo_clk     (fifo_clk),
        .reset        (reset),
        .fifo_flush   (fifo_flush),
        .din          (din),
        .write_busy   (write_busy),
        .read_busy    (read_busy),
        .dout         (a_dout),
        .dout_valid   (a_dout_valid),
        .fifo_full    (a_full),
        .fifo_empty   (a_empty),
        .almost_full  (a_afull),
        .almost_empty (a_aempty),
        .fill_level   (a_level),
        .overflow     (a_ovf),
        .underflow    (a_udf)
    );

    sync_fifo_flags #(
        .WIDTH(8), .DEPTH_LOG2(9)
    ) dut_b (
        .fifo_clk     (fifo_clk),
        .reset        (reset),
        .fifo_flush   (fifo_flush),
        .din          (din_b),
        .write_busy   (write_busy),
        .read_busy    (read_busy),
        .dout         (b_dout),
        .dout_valid   (b_dout_valid),
        .fifo_full    (b_full),
        .fifo_empty   (b_empty),
        .almost_full  (b_afull),
        .almost_empty (b_aempty),
        .fill_level   (b_level),
        .overflow     (b_ovf),
        .underflow    (b_udf)
    );

    initial fifo_clk = 1'b0;
    always #5 fifo_clk = ~fifo_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors = vectors + 1;
        if (actual !== expected) begin
            miscompares = miscompares + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return just after the rising edge.
    task automatic applyStimulus(input logic w, input logic r, input logic [15:0] d,
                                 input logic f, input logic rs);
        @(negedge fifo_clk);
        write_busy = w;
        read_busy  = r;
        din        = d;
        fifo_flush = f;
        reset      = rs;
        @(posedge fifo_clk);
        #1;
    endtask

    // Reference model for the 16x16 instance: a queue holds the stored words.
    logic [15:0] qa[$];
    logic [15:0] ma_dout;
    bit          ma_valid, ma_ovf, ma_udf;
    int          sa;
    always @(posedge fifo_clk) begin
        if (reset) begin
            qa.delete();
            ma_dout = '0; ma_valid = 0; ma_ovf = 0; ma_udf = 0;
        end else if (fifo_flush) begin
            qa.delete();
            ma_valid = 0; ma_ovf = 0; ma_udf = 0;
        end else begin
            sa = qa.size();
            ma_valid = 0;
            if (write_busy && sa == 16) ma_ovf = 1;
            if (read_busy && sa == 0) ma_udf = 1;
            if (read_busy && sa > 0) begin
                ma_dout  = qa.pop_front();
                ma_valid = 1;
            end
            if (write_busy && sa < 16) qa.push_back(din);
        end
    end

    // Reference model for the 512x8 instance.
    logic [7:0] qb[$];
    logic [7:0] mb_dout;
    bit         mb_valid, mb_ovf, mb_udf;
    int         sb;
    always @(posedge fifo_clk) begin
        if (reset) begin
            qb.delete();
            mb_dout = '0; mb_valid = 0; mb_ovf = 0; mb_udf = 0;
        end else if (fifo_flush) begin
            qb.delete();
            mb_valid = 0; mb_ovf = 0; mb_udf = 0;
        end else begin
            sb = qb.size();
            mb_valid = 0;
            if (write_busy && sb == 512) mb_ovf = 1;
            if (read_busy && sb == 0) mb_udf = 1;
            if (read_busy && sb > 0) begin
                mb_dout  = qb.pop_front();
                mb_valid = 1;
            end
            if (write_busy && sb < 512) qb.push_back(din[7:0]);
        end
    end

    // Compare both DUTs against their models in the middle of every cycle.
    always @(negedge fifo_clk) begin
        if (check_en) begin
            checkOutput("a_dout",       a_dout,       ma_dout);
            checkOutput("a_dout_valid", a_dout_valid, ma_valid);
            checkOutput("a_level",      a_level,      qa.size());
            checkOutput("a_full",       a_full,       qa.size() == 16);
            checkOutput("a_empty",      a_empty,      qa.size() == 0);
            checkOutput("a_afull",      a_afull,      qa.size() >= 12);
            checkOutput("a_aempty",     a_aempty,     qa.size() <= 2);
            checkOutput("a_overflow",   a_ovf,        ma_ovf);
            checkOutput("a_underflow",  a_udf,        ma_udf);
            checkOutput("b_dout",       b_dout,       mb_dout);
            checkOutput("b_dout_valid", b_dout_valid, mb_valid);
            checkOutput("b_level",      b_level,      qb.size());
            checkOutput("b_full",       b_full,       qb.size() == 512);
            checkOutput("b_empty",      b_empty,      qb.size() == 0);
            checkOutput("b_afull",      b_afull,      qb.size() >= 508);
            checkOutput("b_aempty",     b_aempty,     qb.size() <= 4);
            checkOutput("b_overflow",   b_ovf,        mb_ovf);
            checkOutput("b_underflow",  b_udf,        mb_udf);
        end
    end

    // Directed test sequence with literal spot checks.
    initial begin
        reset = 1'b1; fifo_flush = 1'b0; din = '0; write_busy = 1'b0; read_busy = 1'b0;
        applyStimulus(0, 0, 16'h0, 0, 1);
        applyStimulus(0, 0, 16'h0, 0, 1);
        check_en = 1;

        $display("[TB] reset during traffic");
        for (int i = 0; i < 5; i++) applyStimulus(1, i > 1, 16'h0100 + 16'(i), 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, 16'h01FF, 0, 1);
        checkOutput("rst_level",  a_level, 0);
        checkOutput("rst_empty",  a_empty, 1);
        checkOutput("rst_aempty", a_aempty, 1);
        checkOutput("rst_dout",   a_dout, 0);
        checkOutput("rst_valid",  a_dout_valid, 0);
        checkOutput("rst_ovf",    a_ovf, 0);
        checkOutput("rst_udf",    a_udf, 0);

        $display("[TB] fill and drain");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 0, 16'(i), 0, 0);
            if (i == 10) checkOutput("fill_afull_11", a_afull, 0);
            if (i == 11) checkOutput("fill_afull_12", a_afull, 1);
            if (i == 14) checkOutput("fill_full_15", a_full, 0);
        end
        checkOutput("fill_full_16", a_full, 1);
        checkOutput("fill_level",   a_level, 16);
        checkOutput("b_level_16",   b_level, 16);
        checkOutput("b_not_full",   b_full, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 1, 16'h0, 0, 0);
            checkOutput("drain_dout",  a_dout, i);
            checkOutput("drain_valid", a_dout_valid, 1);
        end
        checkOutput("drain_empty", a_empty, 1);
        applyStimulus(0, 0, 16'h0, 0, 0);
        checkOutput("idle_valid", a_dout_valid, 0);
        checkOutput("idle_hold",  a_dout, 16'h000F);

        $display("[TB] pointer wrap");
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 16'hA000 + 16'(i), 0, 0);
        checkOutput("wrap_peak", a_level, 10);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 16'h0, 0, 0);
        for (int i = 0; i < 10; i++) applyStimulus(1, 0, 16'hB000 + 16'(i), 0, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1, 16'h0, 0, 0);
            checkOutput("wrap_dout", a_dout, 16'hB000 + i);
        end

        $display("[TB] full and empty boundaries");
        for (int i = 0; i < 16; i++) applyStimulus(1, 0, 16'hC000 + 16'(i), 0, 0);
        applyStimulus(1, 1, 16'hDEAD, 0, 0);
        checkOutput("full_pp_level", a_level, 15);
        checkOutput("full_pp_ovf",   a_ovf, 1);
        checkOutput("full_pp_dout",  a_dout, 16'hC000);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 16'h0, 0, 0);
        checkOutput("drained_last", a_dout, 16'hC00F);
        applyStimulus(1, 1, 16'hBEEF, 0, 0);
        checkOutput("empty_pp_level", a_level, 1);
        checkOutput("empty_pp_udf",   a_udf, 1);
        checkOutput("empty_pp_valid", a_dout_valid, 0);

        $display("[TB] flush");
        for (int i = 0; i < 6; i++) applyStimulus(1, 0, 16'h5000 + 16'(i), 0, 0);
        checkOutput("pre_flush_level", a_level, 7);
        applyStimulus(1, 0, 16'h1234, 1, 0);
        checkOutput("flush_level", a_level, 0);
        checkOutput("flush_empty", a_empty, 1);
        checkOutput("flush_ovf",   a_ovf, 0);
        checkOutput("flush_udf",   a_udf, 0);
        applyStimulus(0, 0, 16'h0, 0, 0);
        checkOutput("flush_nostore", a_level, 0);

        $display("[TB] streaming");
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 16'hD000 + 16'(i), 0, 0);
        for (int i = 0; i < 100; i++) applyStimulus(1, 1, 16'hE000 + 16'(i), 0, 0);
        checkOutput("stream_level", a_level, 3);
        checkOutput("stream_b_lvl", b_level, 3);
        checkOutput("stream_ovf",   a_ovf, 0);
        checkOutput("stream_udf",   a_udf, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 16'h0, 0, 0);
        checkOutput("stream_last", a_dout, 16'hE063);
        checkOutput("stream_b_last", b_dout, 8'h63);
        applyStimulus(0, 0, 16'h0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
